// File: rtl/snake_pkg.sv
// Shared heading type, direction constants and the 180-degree reverse helper
// for the snake direction controller.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Circular buffer of pending turns (DEPTH 1..4). Exposes head and tail so the
// caller can validate against the newest entry and apply the oldest one.
module snake_dir_fifo
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  dir_t       push_data,
  input  logic       pop,
  input  logic       clear,
  output dir_t       head,
  output dir_t       tail,
  output logic [2:0] count
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);

  dir_t       mem_q [4];
  logic [1:0] rd_q, rd_d;
  logic [1:0] wr_q, wr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] tail_idx;

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = 2'd0;
      wr_d  = 2'd0;
      cnt_d = 3'd0;
    end else begin
      if (push) wr_d = bump(wr_q);
      if (pop)  rd_d = bump(rd_q);
      if (push && !pop)      cnt_d = cnt_q + 3'd1;
      else if (pop && !push) cnt_d = cnt_q - 3'd1;
    end
  end

  // Full with simultaneous push+pop writes the slot being vacated; the head
  // value is read combinationally before the edge, so this is safe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q  <= 2'd0;
      wr_q  <= 2'd0;
      cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= DIR_UP;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push && !clear) mem_q[wr_q] <= push_data;
    end
  end

  always_comb tail_idx = (wr_q == 2'd0) ? LAST : wr_q - 2'd1;

  assign head  = mem_q[rd_q];
  assign tail  = mem_q[tail_idx];
  assign count = cnt_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced button presses into the snake heading via a turn queue.
// Optional pause button/flag is enabled with `define SNAKE_DIR_PAUSE_EN.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [1:0]  INIT_DIR    = 2'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       game_tick,
  input  logic       game_restart,
`ifdef SNAKE_DIR_PAUSE_EN
  input  logic       btn_center,
  output logic       paused,
`endif
  output logic [1:0] dir,
  output logic       turn_pulse,
  output logic [2:0] queue_count,
  output logic       drop_pulse
);

  localparam logic [2:0] DEPTH_C = 3'(QUEUE_DEPTH);

  logic [3:0] btn_vec, prev_q, press;
  dir_t       dir_q, dir_d;
  logic       turn_q, turn_d;
  logic       drop_q, drop_d;
  logic       has_press;
  dir_t       press_dir, ref_dir;
  logic       legal, active, room, do_pop, do_push, hold;
  dir_t       fifo_head, fifo_tail;
  logic [2:0] fifo_count;

  assign btn_vec = {btn_left, btn_down, btn_right, btn_up};
  assign press   = btn_vec & ~prev_q;

`ifdef SNAKE_DIR_PAUSE_EN
  logic prev_center_q, paused_q, paused_d;

  always_comb begin
    paused_d = paused_q ^ (btn_center & ~prev_center_q);
    if (game_restart) paused_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_center_q <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      prev_center_q <= btn_center;
      paused_q      <= paused_d;
    end
  end

  assign hold   = paused_q;
  assign paused = paused_q;
`else
  assign hold = 1'b0;
`endif

  // Only the highest-priority new press is considered: UP > RIGHT > DOWN > LEFT.
  always_comb begin
    has_press = 1'b1;
    press_dir = DIR_UP;
    if (press[0])      press_dir = DIR_UP;
    else if (press[1]) press_dir = DIR_RIGHT;
    else if (press[2]) press_dir = DIR_DOWN;
    else if (press[3]) press_dir = DIR_LEFT;
    else               has_press = 1'b0;
  end

  always_comb begin
    ref_dir = (fifo_count != 3'd0) ? fifo_tail : dir_q;
    legal   = has_press && (press_dir != ref_dir) && (press_dir != opposite(ref_dir));
    active  = !game_restart && !hold;
    do_pop  = active && game_tick && (fifo_count != 3'd0);
    room    = (fifo_count < DEPTH_C) || do_pop;
    do_push = active && legal && room;
    drop_d  = active && legal && !room;
    turn_d  = do_pop;
    dir_d   = dir_q;
    if (game_restart) dir_d = INIT_DIR;
    else if (do_pop)  dir_d = fifo_head;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 4'b0000;
      dir_q  <= INIT_DIR;
      turn_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      prev_q <= btn_vec;
      dir_q  <= dir_d;
      turn_q <= turn_d;
      drop_q <= drop_d;
    end
  end

  snake_dir_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (do_push),
    .push_data(press_dir),
    .pop      (do_pop),
    .clear    (game_restart),
    .head     (fifo_head),
    .tail     (fifo_tail),
    .count    (fifo_count)
  );

  assign dir         = dir_q;
  assign turn_pulse  = turn_q;
  assign drop_pulse  = drop_q;
  assign queue_count = fifo_count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl: a behavioural queue model predicts each
// cycle's registered outputs, plus directed checks of the key scenarios.
module tb_snake_dir_ctrl;

  localparam int QD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       game_tick = 1'b0, game_restart = 1'b0;
  logic [1:0] dir;
  logic       turn_pulse, drop_pulse;
  logic [2:0] queue_count;
`ifdef SNAKE_DIR_PAUSE_EN
  logic       btn_center = 1'b0;
  logic       paused;
`endif

  snake_dir_ctrl #(
    .QUEUE_DEPTH(QD),
    .INIT_DIR   (2'd1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_right   (btn_right),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .game_tick   (game_tick),
    .game_restart(game_restart),
`ifdef SNAKE_DIR_PAUSE_EN
    .btn_center  (btn_center),
    .paused      (paused),
`endif
    .dir         (dir),
    .turn_pulse  (turn_pulse),
    .queue_count (queue_count),
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dir;
    logic       turn;
    logic [2:0] cnt;
    logic       drop;
  } exp_t;

  exp_t       sb[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;

  logic [1:0] m_dir = 2'd1;
  logic [1:0] m_q[$];
  logic [3:0] m_prev = 4'b0;
  logic       m_turn = 1'b0, m_drop = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model(input logic [3:0] b, input logic t, input logic r, input logic rst);
    logic [3:0] pr;
    logic [1:0] p, rf, hd;
    logic       hp, pop, legal;
    if (!rst) begin
      m_dir = 2'd1; m_q.delete(); m_prev = 4'b0; m_turn = 1'b0; m_drop = 1'b0;
      return;
    end
    pr = b & ~m_prev;
    m_prev = b;
    if (r) begin
      m_q.delete(); m_dir = 2'd1; m_turn = 1'b0; m_drop = 1'b0;
      return;
    end
    hp = 1'b1;
    if (pr[0]) p = 2'd0;
    else if (pr[1]) p = 2'd1;
    else if (pr[2]) p = 2'd2;
    else if (pr[3]) p = 2'd3;
    else begin hp = 1'b0; p = 2'd0; end
    rf    = (m_q.size() > 0) ? m_q[$] : m_dir;
    legal = hp && (p != rf) && (p != (rf ^ 2'b10));
    pop   = t && (m_q.size() > 0);
    hd    = pop ? m_q[0] : m_dir;
    m_turn = pop;
    m_drop = 1'b0;
    if (pop) begin
      m_dir = hd;
      void'(m_q.pop_front());
    end
    if (legal) begin
      if (m_q.size() < QD) m_q.push_back(p);
      else m_drop = 1'b1;
    end
  endtask

  // b = {left, down, right, up}
  task automatic step(input logic [3:0] b, input logic t, input logic r, input logic rst = 1'b1);
    exp_t e;
    reset = rst;
    {btn_left, btn_down, btn_right, btn_up} = b;
    game_tick = t;
    game_restart = r;
    model(b, t, r, rst);
    sb.push_back('{dir: m_dir, turn: m_turn, cnt: 3'(m_q.size()), drop: m_drop});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("dir", dir, e.dir);
      chk("turn_pulse", turn_pulse, e.turn);
      chk("queue_count", queue_count, e.cnt);
      chk("drop_pulse", drop_pulse, e.drop);
    end
  endtask

  initial begin
    #1;
    // reset, then three idle ticks
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst_dir", dir, 1);
    chk("rst_cnt", queue_count, 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1, 1'b0);
      chk("idle_tick_dir", dir, 1);
      chk("idle_tick_turn", turn_pulse, 0);
    end

    // reverse and same-direction presses are ignored
    step(4'b1000, 1'b0, 1'b0);
    chk("rev_cnt", queue_count, 0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    chk("same_drop", drop_pulse, 0);
    step(4'b0000, 1'b1, 1'b0);
    chk("ign_dir", dir, 1);
    chk("ign_turn", turn_pulse, 0);

    // UP then LEFT buffered, applied one per tick
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("two_cnt", queue_count, 2);
    step(4'b0000, 1'b1, 1'b0);
    chk("tick1_dir", dir, 0);
    chk("tick1_turn", turn_pulse, 1);
    step(4'b0000, 1'b0, 1'b0);
    chk("gap_turn", turn_pulse, 0);
    step(4'b0000, 1'b1, 1'b0);
    chk("tick2_dir", dir, 3);
    chk("tick2_turn", turn_pulse, 1);

    // queue full: drop, then push accepted alongside a pop
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    chk("full_drop", drop_pulse, 1);
    chk("full_cnt", queue_count, 2);
    step(4'b0000, 1'b0, 1'b0);
    chk("drop_once", drop_pulse, 0);
    step(4'b0100, 1'b1, 1'b0);
    chk("pushpop_cnt", queue_count, 2);
    chk("pushpop_dir", dir, 0);
    chk("pushpop_drop", drop_pulse, 0);
    step(4'b0000, 1'b1, 1'b0);
    chk("flush1_dir", dir, 3);
    step(4'b0000, 1'b1, 1'b0);
    chk("flush2_dir", dir, 2);

    // simultaneous UP+LEFT rise: only UP queued
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b0);
    chk("multi_cnt", queue_count, 1);
    chk("multi_drop", drop_pulse, 0);
    step(4'b0000, 1'b0, 1'b0);

    // restart beats tick and press with a full queue
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("pre_rst_cnt", queue_count, 2);
    step(4'b0100, 1'b1, 1'b1);
    chk("restart_dir", dir, 1);
    chk("restart_cnt", queue_count, 0);
    chk("restart_turn", turn_pulse, 0);
    chk("restart_drop", drop_pulse, 0);

    // button held through restart: no press afterwards
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    chk("held_restart_cnt", queue_count, 0);

    // button held through reset: one press after release
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("held_reset_cnt", queue_count, 1);
    step(4'b0000, 1'b1, 1'b0);
    chk("held_reset_dir", dir, 0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] b;
      logic t, r;
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      t = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 40) == 0);
      step(b, t, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Consumes the four debounced (clean, level) direction buttons and turns presses into the snake's heading.
- Detects press edges and rejects illegal turns: same direction, or a 180° reverse.
- Buffers accepted turns in a small FIFO, applying one per game tick, so quick double-taps between ticks are not lost.
- Sits between the per-button debounce stages and the snake movement/game-tick logic.

Parameters:
- QUEUE_DEPTH, 2: turn FIFO entries (1..4).
- INIT_DIR, 2'd1: heading after reset/restart (RIGHT).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-low reset
- btn_up  in  1  debounced level, 1 = pressed
- btn_right  in  1  debounced level
- btn_down  in  1  debounced level
- btn_left  in  1  debounced level
- game_tick  in  1  one-cycle pulse per snake step; consumes one queued turn
- game_restart  in  1  one-cycle pulse; clears state to INIT_DIR
- dir  out  2  current heading: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
- turn_pulse  out  1  one-cycle pulse in the cycle after dir changes
- queue_count  out  3  number of queued turns (0..QUEUE_DEPTH)
- drop_pulse  out  1  one-cycle pulse when an otherwise-legal press is discarded because the queue is full

Behaviour:
- Reset is sampled only on posedge clk while reset==0. Reset values:
  - dir=INIT_DIR, queue empty, queue_count=0, turn_pulse=0, drop_pulse=0.
  - All button history registers are 0.
- Edge detect:
  - press_x = btn_x & ~prev_x; prev_x <= btn_x every cycle, including during game_restart.
  - A button held through reset therefore registers one press after reset release; a button held through restart does not.
- Multiple presses in one cycle: only the highest priority is considered (UP > RIGHT > DOWN > LEFT); the rest are ignored and do not raise drop_pulse.
- Reference heading ref = tail entry of the queue if queue_count>0, else dir. Both are evaluated before any pop in the same cycle.
- A press p is legal iff p != ref and p != (ref ^ 2'b10).
  - Illegal presses are silently ignored: no state change, no pulse.
- A legal press is pushed at the tail if queue_count < QUEUE_DEPTH, or if queue_count == QUEUE_DEPTH and a pop occurs in the same cycle. Otherwise it is dropped and drop_pulse=1 in the next cycle.
- game_tick with queue_count>0:
  - dir <= head and pop, on the same edge.
  - turn_pulse=1 in the following cycle.
- game_tick with an empty queue: dir is unchanged, no pulse.
- A push and a tick in the same cycle with an empty queue: the press is validated against dir and enqueued; it is not applied this tick.
- Push and pop in the same cycle leave queue_count unchanged.
- game_restart has priority over tick and press:
  - Queue cleared, dir <= INIT_DIR; turn_pulse and drop_pulse are 0 next cycle.
  - Presses in that cycle are discarded.
- Latency: press → queue entry 1 cycle; queued entry → dir on the next game_tick edge.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: SNAKE_DIR_PAUSE_EN.
- When defined, the block adds:
  - Input btn_center (debounced level).
  - Output paused (reset 0).
- A btn_center rising edge toggles paused.
- While paused=1:
  - game_tick is ignored (no pop, dir frozen).
  - Direction presses are discarded with no drop_pulse.
  - The queue contents are held.
- game_restart clears paused to 0.
- When the macro is undefined: no extra ports, and behaviour is exactly as above.

Decomposition:
- Package snake_pkg holds:
  - typedef dir_t (2-bit).
  - Constants DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - Function opposite(d) = d ^ 2'b10.
- One sub-module, snake_dir_fifo, is natural: a parameterised circular buffer with depth QUEUE_DEPTH.
  - Ports: push, push_data, pop, clear.
  - Outputs: head, tail, count.
  - Simultaneous push+pop allowed when full.
- Edge detection and legality checking stay in the top module.

Test Plan:
- Reset release with all buttons 0, then 3 game_ticks → dir=1 throughout, turn_pulse never 1, queue_count=0.
- dir=RIGHT; press LEFT (reverse), then RIGHT (same), then tick → both ignored, dir=1, no drop_pulse.
- dir=RIGHT; press UP then LEFT before the tick, then 2 ticks → after tick1 dir=0, after tick2 dir=3, turn_pulse once per tick.
- QUEUE_DEPTH=2, dir=RIGHT; press UP, LEFT, DOWN with no tick → queue_count=2, drop_pulse on the DOWN press; then press DOWN again in the same cycle as a tick → accepted (ref=LEFT), queue_count stays 2.
- btn_up and btn_left rise in the same cycle with dir=RIGHT → only UP queued, queue_count=1.
- Queue holds 2 entries, game_restart pulsed together with a tick and a press → next cycle dir=1, queue_count=0, turn_pulse=0, drop_pulse=0.
